// File: rtl/a5_keystream_ctrl.sv
// Sequencer for the A5/1-style X/Y/Z keystream LFSRs: clear, serial key/frame load,
// majority-clocked warm-up, then keystream bytes over valid/ready (stall freezes the LFSRs).
module a5_keystream_ctrl #(
  parameter int KEY_W     = 64,
  parameter int FRAME_W   = 22,
  parameter int WARMUP    = 100,
  parameter int NUM_BYTES = 16384
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  input  logic               x_clk_bit,
  input  logic               y_clk_bit,
  input  logic               z_clk_bit,
  input  logic               x_msb,
  input  logic               y_msb,
  input  logic               z_msb,
  output logic               lfsr_clr,
  output logic               shift_bit,
  output logic               trig_x,
  output logic               trig_y,
  output logic               trig_z,
  output logic [7:0]         ks_byte,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic               busy,
  output logic               done
);

  localparam int BW = $clog2(NUM_BYTES + 1);

  typedef enum logic [2:0] {IDLE, CLR, KEY, FRAME, WARM, GEN, DONE} state_t;

  state_t             state, state_n;
  logic [6:0]         phase;
  logic [2:0]         bit_cnt;
  logic [BW-1:0]      byte_cnt;
  logic [6:0]         sr;
  logic [KEY_W-1:0]   key_sr;
  logic [FRAME_W-1:0] frame_sr;

  logic maj, stall, xfer, last_xfer, gen_step, capture, byte_done, ks_bit;

  assign maj       = (x_clk_bit & y_clk_bit) | (x_clk_bit & z_clk_bit) | (y_clk_bit & z_clk_bit);
  assign stall     = ks_valid & ~ks_ready;
  assign xfer      = ks_valid & ks_ready;
  assign last_xfer = xfer && (byte_cnt == BW'(NUM_BYTES - 1));
  assign gen_step  = (state == GEN) && !stall && !last_xfer;
  // The first GEN step has no completed step to sample from yet.
  assign capture   = gen_step && (phase != 7'd0);
  assign byte_done = capture && (bit_cnt == 3'd7);
  assign ks_bit    = x_msb ^ y_msb ^ z_msb;

  always_comb begin
    state_n   = state;
    shift_bit = 1'b0;
    trig_x    = 1'b0;
    trig_y    = 1'b0;
    trig_z    = 1'b0;
    case (state)
      IDLE:  if (start) state_n = CLR;
      CLR:   state_n = KEY;
      KEY: begin
        {trig_x, trig_y, trig_z} = 3'b111;
        shift_bit = key_sr[0];
        if (phase == 7'(KEY_W - 1)) state_n = FRAME;
      end
      FRAME: begin
        {trig_x, trig_y, trig_z} = 3'b111;
        shift_bit = frame_sr[0];
        if (phase == 7'(FRAME_W - 1)) state_n = WARM;
      end
      WARM: begin
        trig_x = (x_clk_bit == maj);
        trig_y = (y_clk_bit == maj);
        trig_z = (z_clk_bit == maj);
        if (phase == 7'(WARMUP - 1)) state_n = GEN;
      end
      GEN: begin
        if (gen_step) begin
          trig_x = (x_clk_bit == maj);
          trig_y = (y_clk_bit == maj);
          trig_z = (z_clk_bit == maj);
        end
        if (last_xfer) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sr       <= '0;
      key_sr   <= '0;
      frame_sr <= '0;
      lfsr_clr <= 1'b0;
      ks_byte  <= 8'h00;
      ks_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      lfsr_clr <= (state_n == CLR);
      done     <= (state_n == DONE);

      if (state == IDLE && start) begin
        busy     <= 1'b1;
        key_sr   <= key;
        frame_sr <= frame;
      end else if (state_n == DONE) begin
        busy <= 1'b0;
      end

      if (state_n != state) phase <= '0;
      else if (state == KEY || state == FRAME || state == WARM) phase <= phase + 7'd1;
      else if (gen_step) phase <= 7'd1;

      // Load bits are consumed LSB first by shifting the working copies.
      if (state == KEY)   key_sr   <= key_sr >> 1;
      if (state == FRAME) frame_sr <= frame_sr >> 1;

      if (state == CLR) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end

      if (capture) begin
        sr      <= {sr[5:0], ks_bit};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        ks_byte  <= {sr, ks_bit};
        ks_valid <= 1'b1;
      end else if (xfer) begin
        ks_valid <= 1'b0;
      end

      if (xfer) byte_cnt <= byte_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_a5_keystream_ctrl.sv
// Bench for a5_keystream_ctrl: real X/Y/Z registers attached, reference A5/1 keystream
// computed algorithmically, and a cycle-index model checked every negedge.
module tb_a5_keystream_ctrl;

  localparam int KW = 64;
  localparam int FW = 22;
  localparam int WU = 100;
  localparam int NB = 4;
  localparam logic [63:0] KA = 64'h0123_4567_89AB_CDEF;
  localparam logic [21:0] FA = 22'h134;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [KW-1:0] key;
  logic [FW-1:0] frame;
  logic          x_clk_bit, y_clk_bit, z_clk_bit, x_msb, y_msb, z_msb;
  logic          lfsr_clr, shift_bit, trig_x, trig_y, trig_z;
  logic [7:0]    ks_byte;
  logic          ks_valid, ks_ready, busy, done;

  always #5 clk = ~clk;

  a5_keystream_ctrl #(.KEY_W(KW), .FRAME_W(FW), .WARMUP(WU), .NUM_BYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key), .frame(frame),
    .x_clk_bit(x_clk_bit), .y_clk_bit(y_clk_bit), .z_clk_bit(z_clk_bit),
    .x_msb(x_msb), .y_msb(y_msb), .z_msb(z_msb),
    .lfsr_clr(lfsr_clr), .shift_bit(shift_bit),
    .trig_x(trig_x), .trig_y(trig_y), .trig_z(trig_z),
    .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .busy(busy), .done(done)
  );

  function automatic logic [18:0] nx(input logic [18:0] r, input logic b);
    return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13] ^ b};
  endfunction
  function automatic logic [21:0] ny(input logic [21:0] r, input logic b);
    return {r[20:0], r[21] ^ r[20] ^ b};
  endfunction
  function automatic logic [22:0] nz(input logic [22:0] r, input logic b);
    return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7] ^ b};
  endfunction
  function automatic logic [2:0] majtrig(input logic x, input logic y, input logic z);
    logic m;
    m = (int'(x) + int'(y) + int'(z)) >= 2;
    return {x == m, y == m, z == m};
  endfunction

  // Attached X/Y/Z registers, with an override path for the tap bits.
  logic [18:0] rx = '0;
  logic [21:0] ry = '0;
  logic [22:0] rz = '0;
  logic        force_taps = 1'b0;
  logic        fx = 1'b0, fy = 1'b0, fz = 1'b0;

  always @(posedge clk) begin
    if (lfsr_clr) begin
      rx <= '0; ry <= '0; rz <= '0;
    end else begin
      if (trig_x) rx <= nx(rx, shift_bit);
      if (trig_y) ry <= ny(ry, shift_bit);
      if (trig_z) rz <= nz(rz, shift_bit);
    end
  end

  assign x_clk_bit = force_taps ? fx : rx[8];
  assign y_clk_bit = force_taps ? fy : ry[10];
  assign z_clk_bit = force_taps ? fz : rz[10];
  assign x_msb = rx[18];
  assign y_msb = ry[21];
  assign z_msb = rz[22];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference keystream: plain A5/1 key/frame loading, warm-up, then step-and-output.
  logic [7:0] m_ref [NB];

  task automatic build_ref(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [2:0]  t;
    logic [7:0]  b;
    r1 = '0; r2 = '0; r3 = '0;
    for (int i = 0; i < KW; i++) begin r1 = nx(r1, k[i]); r2 = ny(r2, k[i]); r3 = nz(r3, k[i]); end
    for (int i = 0; i < FW; i++) begin r1 = nx(r1, f[i]); r2 = ny(r2, f[i]); r3 = nz(r3, f[i]); end
    for (int n = 0; n < WU + 8 * NB; n++) begin
      t = majtrig(r1[8], r2[10], r3[10]);
      if (t[2]) r1 = nx(r1, 1'b0);
      if (t[1]) r2 = ny(r2, 1'b0);
      if (t[0]) r3 = nz(r3, 1'b0);
      if (n >= WU) begin
        b = {b[6:0], r1[18] ^ r2[21] ^ r3[22]};
        if ((n - WU) % 8 == 7) m_ref[(n - WU) / 8] = b;
      end
    end
  endtask

  // Cycle model: m_cyc counts cycles since the accepted start.
  int          m_busy = 0, m_in_done = 0, m_cyc = 0, m_nstep = 0, m_xfer = 0;
  int          m_first_valid = 0, m_done_cnt = 0;
  logic [63:0] m_key = '0;
  logic [21:0] m_frame = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset_outputs", {lfsr_clr, shift_bit, trig_x, trig_y, trig_z, ks_byte, ks_valid, busy, done}, 64'h0);
        m_busy = 0; m_in_done = 0;
      end else begin
        logic [2:0] e_trig;
        logic       e_clr, e_shift, e_valid, e_busy, e_done;
        int         cap;
        bit         stl, xf, lst, in_gen;
        e_trig = 3'b000; e_clr = 0; e_shift = 0; e_valid = 0; e_done = 0;
        e_busy = (m_busy != 0); stl = 0; xf = 0; lst = 0; in_gen = 0;
        if (m_in_done != 0) begin
          e_done = 1; e_busy = 0;
        end else if (m_busy != 0) begin
          if (m_cyc == 1) e_clr = 1;
          else if (m_cyc <= 1 + KW) begin e_trig = 3'b111; e_shift = m_key[m_cyc - 2]; end
          else if (m_cyc <= 1 + KW + FW) begin e_trig = 3'b111; e_shift = m_frame[m_cyc - 2 - KW]; end
          else if (m_cyc <= 1 + KW + FW + WU) e_trig = majtrig(x_clk_bit, y_clk_bit, z_clk_bit);
          else begin
            in_gen  = 1;
            cap     = (m_nstep > 0) ? m_nstep - 1 : 0;
            e_valid = (cap / 8) > m_xfer;
            stl     = e_valid && !ks_ready;
            xf      = e_valid && ks_ready;
            lst     = xf && (m_xfer == NB - 1);
            if (!stl && !lst) e_trig = majtrig(x_clk_bit, y_clk_bit, z_clk_bit);
            if (e_valid && m_xfer < NB) chk("ks_byte", ks_byte, m_ref[m_xfer]);
          end
        end
        chk("lfsr_clr", lfsr_clr, e_clr);
        chk("trig_xyz", {trig_x, trig_y, trig_z}, e_trig);
        chk("shift_bit", shift_bit, e_shift);
        chk("ks_valid", ks_valid, e_valid);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (done) m_done_cnt++;
        if (m_in_done != 0) begin
          m_in_done = 0; m_busy = 0;
        end else if (m_busy != 0) begin
          if (in_gen) begin
            if (e_valid && m_first_valid == 0) m_first_valid = m_cyc;
            if (!stl && !lst) m_nstep++;
            if (xf) m_xfer++;
            if (lst) m_in_done = 1;
          end
          m_cyc++;
        end else if (start) begin
          m_busy = 1; m_cyc = 1; m_nstep = 0; m_xfer = 0;
          m_first_valid = 0; m_done_cnt = 0;
          m_key = key; m_frame = frame;
        end
      end
    end
  end

  logic rdy_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) ks_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_start(input logic [63:0] k, input logic [21:0] f);
    build_ref(k, f);
    @(posedge clk); #1;
    key = k; frame = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1; break; end
    end
    chk("done_seen", seen, 1);
    chk("busy_falls_with_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("done_pulse_count", m_done_cnt, 1);
  endtask

  task automatic wait_valid(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (ks_valid) begin seen = 1; break; end
    end
    chk("valid_seen", seen, 1);
  endtask

  initial begin
    logic [2:0]  pat [3];
    logic [2:0]  pexp [3];
    logic [7:0]  held;
    logic [63:0] rk;
    logic [21:0] rf;
    bit          hit;
    pat  = '{3'b101, 3'b000, 3'b011};
    pexp = '{3'b101, 3'b111, 3'b011};
    reset_n = 1'b0; start = 1'b0; key = '0; frame = '0; ks_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", {lfsr_clr, shift_bit, trig_x, trig_y, trig_z, ks_byte, ks_valid, busy, done}, 64'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Load trace and first-byte latency, ready always high.
    do_start(KA, FA);
    wait_done(600);
    chk("first_valid_latency", m_first_valid - 1, 196);

    // Backpressure plus an ignored second start with another key during KEY.
    do_start(KA, FA);
    repeat (10) @(posedge clk);
    #1;
    key = ~KA; frame = ~FA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(400);
    ks_ready = 1'b0;
    held = ks_byte;
    repeat (20) begin
      @(posedge clk); #1;
      chk("stall_trig", {trig_x, trig_y, trig_z}, 3'b000);
      chk("stall_byte_held", ks_byte, held);
    end
    ks_ready = 1'b1;
    wait_done(600);

    // Random keys with random consumer readiness.
    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      rdy_rand = 1'b1;
      do_start(rk, rf);
      wait_done(2000);
      rdy_rand = 1'b0;
      ks_ready = 1'b1;
    end

    // All-zero key and frame leave the registers at zero, so the stream is zero.
    build_ref('0, '0);
    for (int i = 0; i < NB; i++) chk("ref_zero_stream", m_ref[i], 8'h00);
    do_start('0, '0);
    wait_done(600);

    // Forced tap patterns during warm-up, then abandon the run with reset.
    do_start(KA, FA);
    repeat (100) @(posedge clk);
    #1;
    force_taps = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {fx, fy, fz} = pat[i];
      #1;
      chk("warm_majority", {trig_x, trig_y, trig_z}, pexp[i]);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      {fx, fy, fz} = 3'($urandom);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    force_taps = 1'b0;
    #1;
    chk("abort_in_warm", {trig_x, trig_y, trig_z, busy}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset mid-byte in GEN with five bits of the second byte captured.
    do_start(~KA, FA ^ 22'h2AAAA);
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (m_busy != 0 && m_nstep == 14) begin hit = 1; break; end
    end
    chk("reached_bit5", hit, 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {lfsr_clr, shift_bit, trig_x, trig_y, trig_z, ks_byte, ks_valid, busy, done}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_start(~KA, FA ^ 22'h2AAAA);
    wait_done(600);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/a5_keystream_ctrl.md
Name: a5_keystream_ctrl

Overview:
Sequencer for the three keystream LFSRs X (19 b), Y (22 b) and Z (23 b) used by the image-encryption datapath. On start it clears the registers, then serially loads the 64-bit session key and the 22-bit frame number. It runs the warm-up with majority clocking, then generates keystream bytes. The encryption XOR stage consumes these bytes over a valid/ready handshake.

Parameters:
KEY_W, 64, session key width; one load cycle per bit
FRAME_W, 22, frame number width; one load cycle per bit
WARMUP, 100, majority-clocked steps with output discarded
NUM_BYTES, 16384, keystream bytes per frame (128x128 8-bit image)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle start pulse; ignored while busy=1
key  in  KEY_W  session key; sampled on the accepted start
frame  in  FRAME_W  frame number; sampled on the accepted start
x_clk_bit  in  1  X[8], clocking tap
y_clk_bit  in  1  Y[10], clocking tap
z_clk_bit  in  1  Z[10], clocking tap
x_msb  in  1  X output bit
y_msb  in  1  Y output bit
z_msb  in  1  Z output bit
lfsr_clr  out  1  synchronous clear request to X/Y/Z
shift_bit  out  1  serial bit XORed into the feedback of every triggered LFSR
trig_x  out  1  step X at this clk edge
trig_y  out  1  step Y at this clk edge
trig_z  out  1  step Z at this clk edge
ks_byte  out  8  keystream byte
ks_valid  out  1  ks_byte valid
ks_ready  in  1  consumer accepts ks_byte
busy  out  1  high from the accepted start until DONE
done  out  1  one-cycle pulse when the last byte is accepted

Behaviour:
- Reset values: state=IDLE; all counters 0; lfsr_clr=0, shift_bit=0, trig_*=0, ks_byte=8'h00, ks_valid=0, busy=0, done=0.
- Output timing:
  - trig_* and shift_bit are combinational decodes of state, counters and the tap inputs. The taps are LFSR register outputs, so there is no combinational loop.
  - All other outputs are registered.
- States: IDLE -> CLR -> KEY -> FRAME -> WARM -> GEN -> DONE -> IDLE.
- IDLE: start=1 latches key and frame, sets busy=1, goes to CLR.
- CLR (1 cycle): lfsr_clr=1, no triggers.
- KEY (KEY_W cycles, i=0..KEY_W-1):
  - trig_x=trig_y=trig_z=1, shift_bit=key[i] (LSB first).
  - Leave after i=KEY_W-1.
- FRAME (FRAME_W cycles): as KEY, with shift_bit=frame[j].
- Majority clocking (WARM and GEN): maj = majority(x_clk_bit, y_clk_bit, z_clk_bit). trig_x=(x_clk_bit==maj), likewise for Y and Z. At least two triggers are always high. shift_bit=0.
- WARM: WARMUP steps, no capture.
- GEN:
  - Step rule: one majority step per cycle unless stalled. Stall when ks_valid=1 and ks_ready=0; a stall forces all trig_*=0.
  - Bit capture: every non-stalled GEN cycle except the first captures b = x_msb^y_msb^z_msb, i.e. the state after the previous step.
  - Bit order: bits fill an 8-bit shift register first-bit-to-MSB.
  - On the 8th bit: ks_byte <= {sr[6:0], b}, ks_valid <= 1, bit count <= 0.
  - Handshake: transfer occurs when ks_valid && ks_ready; ks_valid drops the next cycle unless a new byte completes in the same cycle. ks_byte is held stable while ks_valid=1 and ks_ready=0.
- Byte counter: increments on each transfer. The transfer of byte NUM_BYTES goes to DONE with no further triggers.
- DONE (1 cycle): done=1, busy=0, then IDLE. LFSR contents are retained.
- start while busy: ignored; latched key and frame are unchanged.
- reset_n low mid-operation: immediate return to reset values. Any partial byte is discarded; trig_* go low asynchronously.
- Counter widths: 7 b phase counter (max of KEY_W, FRAME_W, WARMUP); 3 b bit counter; byte counter $clog2(NUM_BYTES+1) b.
- Latency from the accepted start to the first ks_valid: 1+KEY_W+FRAME_W+WARMUP+1+8 cycles = 196 at defaults, with no stalls.

Test Plan:
- Start, load trace: key=64'h0123_4567_89AB_CDEF, frame=22'h134, ks_ready=1.
  -> lfsr_clr for 1 cycle.
  -> 64 cycles with all trig=1 and shift_bit=key[0..63].
  -> 22 cycles with shift_bit=frame[0..21].
  -> first ks_valid 196 cycles after start.
- Same stimulus with real X/Y/Z attached, NUM_BYTES=4 -> ks_byte sequence matches the golden C A5/1 model bit-for-bit; done pulses once after the 4th transfer; busy falls with it.
- Majority decode in WARM:
  - taps (x,y,z)=(1,0,1) -> trig_x=1, trig_y=0, trig_z=1.
  - (0,0,0) -> all three triggers high.
  - (0,1,1) -> trig_x=0, trig_y=1, trig_z=1.
- Backpressure: hold ks_ready=0 for 20 cycles after the first ks_valid -> trig_* all 0 and ks_byte constant throughout. Releasing ready -> one transfer, stepping resumes next cycle, no bit lost or duplicated vs the model.
- Second start pulse issued during KEY with a different key -> ignored; the output stream equals the first-key stream.
- reset_n asserted in GEN mid-byte (bit count 5) -> all outputs 0 asynchronously, state IDLE. A new start yields a stream identical to a fresh run.
